longp_wbck_sched: RTL and testbench
===================================

Name: longp_wbck_sched

Overview:
- Schedules long-pipe write-backs (LSU loads, multi-cycle MUL/DIV) into the single long-pipe port of the final write-back arbiter.
- Completions are retired strictly in OITF order: only the requester whose itag matches the OITF retire pointer may proceed.
- A one-entry registered output slot decouples the requesters from the write-back port.
- Each accepted completion generates the OITF retire strobe.

Parameters:
XLEN, 32, data width of write-back data.
RFIDX_W, 5, register-file index width.
ITAG_W, 2, OITF instruction-tag width (OITF depth = 2**ITAG_W).
TIMEOUT, 1024, stall threshold in cycles, used only with the optional feature.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
oitf_empty  in  1  OITF holds no outstanding entry.
oitf_ret_ptr  in  ITAG_W  itag at OITF head.
oitf_ret_rdidx  in  RFIDX_W  destination register of OITF head.
oitf_ret_rdwen  in  1  OITF head writes a register.
oitf_ret_ena  out  1  retire OITF head (combinational, one per accept).
lsu_wbck_i_valid  in  1  LSU completion valid.
lsu_wbck_i_ready  out  1  LSU completion accepted.
lsu_wbck_i_wdat  in  XLEN  load data.
lsu_wbck_i_itag  in  ITAG_W  LSU completion tag.
lsu_wbck_i_err  in  1  load bus error.
mdv_wbck_i_valid  in  1  MUL/DIV completion valid.
mdv_wbck_i_ready  out  1  MUL/DIV completion accepted.
mdv_wbck_i_wdat  in  XLEN  MUL/DIV result.
mdv_wbck_i_itag  in  ITAG_W  MUL/DIV completion tag.
longp_wbck_o_valid  out  1  write-back request to final arbiter.
longp_wbck_o_ready  in  1  final arbiter accepts.
longp_wbck_o_wdat  out  XLEN  write-back data.
longp_wbck_o_rdidx  out  RFIDX_W  write-back register index.
longp_excp_o_valid  out  1  registered one-cycle pulse: load error retired.
longp_wbck_timeout  out  1  sticky stall flag (optional feature).

Behaviour:
- Eligibility: a requester is eligible when valid, ~oitf_empty, and itag == oitf_ret_ptr.
- Priority: if both are eligible (illegal, but must be defined), LSU wins and MDV ready=0.
- Slot state: single flag slot_full plus registers wdat and rdidx.
- Outputs: longp_wbck_o_valid = slot_full; wdat and rdidx are driven from the slot registers.
- Drain: drain = slot_full & longp_wbck_o_ready.
- Write-back completion (eligible, rdwen=1, err=0):
  - accepted (ready=1) when ~slot_full | drain;
  - slot loads wdat and oitf_ret_rdidx;
  - slot_full=1 next cycle.
- Bypass completion (rdwen=0 or lsu err=1):
  - always accepted the same cycle and never occupies the slot;
  - lsu err sets longp_excp_o_valid for exactly the next cycle.
- Retire: oitf_ret_ena = accept of either requester; exactly one pulse per accepted completion, in the same cycle as the accept.
- Latency:
  - write-back path: accept to longp_wbck_o_valid is 1 cycle;
  - back-to-back accepts every cycle are sustained when longp_wbck_o_ready stays high.
- Back-pressure: slot full and ~longp_wbck_o_ready forces ready=0 on write-back completions. Bypass completions still proceed, since they do not need the slot.
- Drain with no new accept: slot_full clears next cycle.
- Simultaneous drain and accept: slot is overwritten with the new entry and slot_full stays 1.
- oitf_empty=1: both readys are 0 and no retire occurs, regardless of tags.
- Reset (any cycle, including while the slot is full):
  - slot_full=0; wdat and rdidx = 0;
  - longp_wbck_o_valid=0, longp_excp_o_valid=0, longp_wbck_timeout=0;
  - any pending slot contents are discarded;
  - readys and oitf_ret_ena follow the combinational rules above from the cycle after rst deasserts.

Optional Feature:
- Macro: E203_LONGP_WBCK_TIMEOUT_EN.
- With the macro defined:
  - a clog2(TIMEOUT+1)-bit counter increments each cycle that ~oitf_empty and no accept occurs;
  - the counter clears on any accept, or when oitf_empty=1;
  - on reaching TIMEOUT, longp_wbck_timeout is set and remains set until rst.
  - The counter saturates and does not wrap.
- Without the macro: no counter exists and longp_wbck_timeout is tied 0.

Test Plan:
- In-order LSU: oitf_ret_ptr=0, rdidx=5, rdwen=1, LSU valid itag=0 wdat=0xDEADBEEF, wbck_o_ready=1 -> same cycle lsu ready=1 and oitf_ret_ena=1; next cycle wbck_o_valid=1, wdat=0xDEADBEEF, rdidx=5.
- Out-of-order block: ret_ptr=1; MDV valid itag=2 and LSU valid itag=1 -> mdv ready=0, LSU accepted; after ptr advances to 2, MDV accepted on the following cycle.
- Back-pressure: wbck_o_ready=0 with slot full, MDV eligible -> mdv ready=0 and no retire; raise ready -> drain and accept occur in the same cycle, slot_full stays 1 with the MDV data.
- Load error: LSU eligible with err=1, rdwen=1 -> accepted, retire pulse, no wbck_o_valid; longp_excp_o_valid=1 for exactly one cycle.
- Reset mid-operation: slot full and wbck_o_ready=0, assert rst one cycle -> wbck_o_valid=0 next cycle and the slot data is not presented afterward.
- Timeout (macro on, TIMEOUT=8): oitf_empty=0 with no valids for 8 cycles -> longp_wbck_timeout=1 and it stays 1 after a later accept, until rst.

Source files
------------

// File: rtl/longp_wbck_sched.sv
// In-order long-pipe write-back scheduler: LSU and MUL/DIV completions feed one registered slot.
// Optional stall watchdog enabled by defining E203_LONGP_WBCK_TIMEOUT_EN.
module longp_wbck_sched #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int ITAG_W  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               oitf_empty,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    input  logic [RFIDX_W-1:0] oitf_ret_rdidx,
    input  logic               oitf_ret_rdwen,
    output logic               oitf_ret_ena,
    input  logic               lsu_wbck_i_valid,
    output logic               lsu_wbck_i_ready,
    input  logic [XLEN-1:0]    lsu_wbck_i_wdat,
    input  logic [ITAG_W-1:0]  lsu_wbck_i_itag,
    input  logic               lsu_wbck_i_err,
    input  logic               mdv_wbck_i_valid,
    output logic               mdv_wbck_i_ready,
    input  logic [XLEN-1:0]    mdv_wbck_i_wdat,
    input  logic [ITAG_W-1:0]  mdv_wbck_i_itag,
    output logic               longp_wbck_o_valid,
    input  logic               longp_wbck_o_ready,
    output logic [XLEN-1:0]    longp_wbck_o_wdat,
    output logic [RFIDX_W-1:0] longp_wbck_o_rdidx,
    output logic               longp_excp_o_valid,
    output logic               longp_wbck_timeout
);

    logic               slot_full;
    logic [XLEN-1:0]    slot_wdat;
    logic [RFIDX_W-1:0] slot_rdidx;
    logic               excp_q;

    logic lsu_elig;
    logic mdv_elig;
    logic lsu_bypass;
    logic mdv_bypass;
    logic slot_avail;
    logic drain;
    logic lsu_load;
    logic mdv_load;
    logic accept;

    // Only the OITF head may retire; LSU wins the (illegal) tie.
    assign lsu_elig   = lsu_wbck_i_valid & ~oitf_empty & (lsu_wbck_i_itag == oitf_ret_ptr);
    assign mdv_elig   = mdv_wbck_i_valid & ~oitf_empty & (mdv_wbck_i_itag == oitf_ret_ptr) & ~lsu_elig;

    assign lsu_bypass = ~oitf_ret_rdwen | lsu_wbck_i_err;
    assign mdv_bypass = ~oitf_ret_rdwen;

    assign drain      = slot_full & longp_wbck_o_ready;
    assign slot_avail = ~slot_full | drain;

    assign lsu_wbck_i_ready = lsu_elig & (lsu_bypass | slot_avail);
    assign mdv_wbck_i_ready = mdv_elig & (mdv_bypass | slot_avail);

    assign lsu_load = lsu_wbck_i_ready & ~lsu_bypass;
    assign mdv_load = mdv_wbck_i_ready & ~mdv_bypass;
    assign accept   = lsu_wbck_i_ready | mdv_wbck_i_ready;

    assign oitf_ret_ena       = accept;
    assign longp_wbck_o_valid = slot_full;
    assign longp_wbck_o_wdat  = slot_wdat;
    assign longp_wbck_o_rdidx = slot_rdidx;
    assign longp_excp_o_valid = excp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full  <= 1'b0;
            slot_wdat  <= '0;
            slot_rdidx <= '0;
            excp_q     <= 1'b0;
        end else begin
            excp_q <= lsu_wbck_i_ready & lsu_wbck_i_err;
            if (lsu_load | mdv_load) begin
                slot_full  <= 1'b1;
                slot_wdat  <= lsu_load ? lsu_wbck_i_wdat : mdv_wbck_i_wdat;
                slot_rdidx <= oitf_ret_rdidx;
            end else if (drain) begin
                slot_full <= 1'b0;
            end
        end
    end

`ifdef E203_LONGP_WBCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] stall_cnt_nxt;
    logic             timeout_q;

    // Saturating count of cycles the head is outstanding without any retire.
    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (oitf_empty | accept) begin
            stall_cnt_nxt = '0;
        end else if (stall_cnt != CNT_W'(TIMEOUT)) begin
            stall_cnt_nxt = stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
            if (stall_cnt_nxt == CNT_W'(TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign longp_wbck_timeout = timeout_q;
`else
    assign longp_wbck_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_longp_wbck_sched.sv
// Directed self-checking bench for longp_wbck_sched (timeout scenario active with E203_LONGP_WBCK_TIMEOUT_EN).
module tb_longp_wbck_sched;

    localparam int XLEN    = 32;
    localparam int RFIDX_W = 5;
    localparam int ITAG_W  = 2;
    localparam int TIMEOUT = 8;

    logic               clk;
    logic               rst;
    logic               oitf_empty;
    logic [ITAG_W-1:0]  oitf_ret_ptr;
    logic [RFIDX_W-1:0] oitf_ret_rdidx;
    logic               oitf_ret_rdwen;
    logic               oitf_ret_ena;
    logic               lsu_wbck_i_valid;
    logic               lsu_wbck_i_ready;
    logic [XLEN-1:0]    lsu_wbck_i_wdat;
    logic [ITAG_W-1:0]  lsu_wbck_i_itag;
    logic               lsu_wbck_i_err;
    logic               mdv_wbck_i_valid;
    logic               mdv_wbck_i_ready;
    logic [XLEN-1:0]    mdv_wbck_i_wdat;
    logic [ITAG_W-1:0]  mdv_wbck_i_itag;
    logic               longp_wbck_o_valid;
    logic               longp_wbck_o_ready;
    logic [XLEN-1:0]    longp_wbck_o_wdat;
    logic [RFIDX_W-1:0] longp_wbck_o_rdidx;
    logic               longp_excp_o_valid;
    logic               longp_wbck_timeout;

    int total = 0;
    int bad   = 0;

    longp_wbck_sched #(
        .XLEN(XLEN), .RFIDX_W(RFIDX_W), .ITAG_W(ITAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .oitf_empty(oitf_empty),
        .oitf_ret_ptr(oitf_ret_ptr),
        .oitf_ret_rdidx(oitf_ret_rdidx),
        .oitf_ret_rdwen(oitf_ret_rdwen),
        .oitf_ret_ena(oitf_ret_ena),
        .lsu_wbck_i_valid(lsu_wbck_i_valid),
        .lsu_wbck_i_ready(lsu_wbck_i_ready),
        .lsu_wbck_i_wdat(lsu_wbck_i_wdat),
        .lsu_wbck_i_itag(lsu_wbck_i_itag),
        .lsu_wbck_i_err(lsu_wbck_i_err),
        .mdv_wbck_i_valid(mdv_wbck_i_valid),
        .mdv_wbck_i_ready(mdv_wbck_i_ready),
        .mdv_wbck_i_wdat(mdv_wbck_i_wdat),
        .mdv_wbck_i_itag(mdv_wbck_i_itag),
        .longp_wbck_o_valid(longp_wbck_o_valid),
        .longp_wbck_o_ready(longp_wbck_o_ready),
        .longp_wbck_o_wdat(longp_wbck_o_wdat),
        .longp_wbck_o_rdidx(longp_wbck_o_rdidx),
        .longp_excp_o_valid(longp_excp_o_valid),
        .longp_wbck_timeout(longp_wbck_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks happen 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        lsu_wbck_i_valid = 1'b0;
        lsu_wbck_i_err   = 1'b0;
        mdv_wbck_i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        oitf_empty = 1'b1;
        oitf_ret_ptr = '0;
        oitf_ret_rdidx = '0;
        oitf_ret_rdwen = 1'b0;
        lsu_wbck_i_wdat = '0;
        lsu_wbck_i_itag = '0;
        mdv_wbck_i_wdat = '0;
        mdv_wbck_i_itag = '0;
        longp_wbck_o_ready = 1'b0;
        idle_inputs();
        step();
        step();
        settle();
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", longp_wbck_o_valid); end
        total++; if (longp_wbck_o_wdat !== 32'h0) begin bad++; $display("FAIL reset_wdat got=%h want=0", longp_wbck_o_wdat); end
        total++; if (longp_wbck_o_rdidx !== 5'd0) begin bad++; $display("FAIL reset_rdidx got=%0d want=0", longp_wbck_o_rdidx); end
        total++; if (longp_excp_o_valid !== 1'b0) begin bad++; $display("FAIL reset_excp got=%b want=0", longp_excp_o_valid); end
        total++; if (longp_wbck_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", longp_wbck_timeout); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_in_order_lsu();
        oitf_empty = 1'b0;
        oitf_ret_ptr = 2'd0;
        oitf_ret_rdidx = 5'd5;
        oitf_ret_rdwen = 1'b1;
        longp_wbck_o_ready = 1'b1;
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd0;
        lsu_wbck_i_wdat = 32'hDEADBEEF;
        settle();
        total++; if (lsu_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL inorder_lsu_ready got=%b want=1", lsu_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL inorder_ret_ena got=%b want=1", oitf_ret_ena); end
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL inorder_valid_early got=%b want=0", longp_wbck_o_valid); end
        step();
        idle_inputs();
        oitf_ret_ptr = 2'd1;
        oitf_ret_rdidx = 5'd0;
        settle();
        total++; if (longp_wbck_o_valid !== 1'b1) begin bad++; $display("FAIL inorder_valid got=%b want=1", longp_wbck_o_valid); end
        total++; if (longp_wbck_o_wdat !== 32'hDEADBEEF) begin bad++; $display("FAIL inorder_wdat got=%h want=deadbeef", longp_wbck_o_wdat); end
        total++; if (longp_wbck_o_rdidx !== 5'd5) begin bad++; $display("FAIL inorder_rdidx got=%0d want=5", longp_wbck_o_rdidx); end
        total++; if (oitf_ret_ena !== 1'b0) begin bad++; $display("FAIL inorder_no_ret got=%b want=0", oitf_ret_ena); end
        step();
        settle();
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL inorder_drained got=%b want=0", longp_wbck_o_valid); end
    endtask

    task automatic test_out_of_order();
        oitf_ret_ptr = 2'd1;
        oitf_ret_rdidx = 5'd7;
        oitf_ret_rdwen = 1'b1;
        longp_wbck_o_ready = 1'b1;
        mdv_wbck_i_valid = 1'b1;
        mdv_wbck_i_itag = 2'd2;
        mdv_wbck_i_wdat = 32'h11111111;
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd1;
        lsu_wbck_i_wdat = 32'h22222222;
        settle();
        total++; if (mdv_wbck_i_ready !== 1'b0) begin bad++; $display("FAIL ooo_mdv_blocked got=%b want=0", mdv_wbck_i_ready); end
        total++; if (lsu_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL ooo_lsu_ready got=%b want=1", lsu_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL ooo_ret_lsu got=%b want=1", oitf_ret_ena); end
        step();
        lsu_wbck_i_valid = 1'b0;
        oitf_ret_ptr = 2'd2;
        oitf_ret_rdidx = 5'd9;
        settle();
        total++; if (mdv_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL ooo_mdv_ready got=%b want=1", mdv_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL ooo_ret_mdv got=%b want=1", oitf_ret_ena); end
        total++; if (longp_wbck_o_wdat !== 32'h22222222) begin bad++; $display("FAIL ooo_wdat_lsu got=%h want=22222222", longp_wbck_o_wdat); end
        total++; if (longp_wbck_o_rdidx !== 5'd7) begin bad++; $display("FAIL ooo_rdidx_lsu got=%0d want=7", longp_wbck_o_rdidx); end
        step();
        idle_inputs();
        oitf_ret_ptr = 2'd3;
        settle();
        total++; if (longp_wbck_o_valid !== 1'b1) begin bad++; $display("FAIL ooo_valid_mdv got=%b want=1", longp_wbck_o_valid); end
        total++; if (longp_wbck_o_wdat !== 32'h11111111) begin bad++; $display("FAIL ooo_wdat_mdv got=%h want=11111111", longp_wbck_o_wdat); end
        total++; if (longp_wbck_o_rdidx !== 5'd9) begin bad++; $display("FAIL ooo_rdidx_mdv got=%0d want=9", longp_wbck_o_rdidx); end
        step();
    endtask

    task automatic test_back_pressure();
        // Fill slot with LSU data while the arbiter is stalled.
        longp_wbck_o_ready = 1'b0;
        oitf_ret_ptr = 2'd3;
        oitf_ret_rdidx = 5'd4;
        oitf_ret_rdwen = 1'b1;
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd3;
        lsu_wbck_i_wdat = 32'h0000AAAA;
        settle();
        total++; if (lsu_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL bp_fill_ready got=%b want=1", lsu_wbck_i_ready); end
        step();
        idle_inputs();
        oitf_ret_ptr = 2'd0;
        oitf_ret_rdidx = 5'd6;
        mdv_wbck_i_valid = 1'b1;
        mdv_wbck_i_itag = 2'd0;
        mdv_wbck_i_wdat = 32'h0000BBBB;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (mdv_wbck_i_ready !== 1'b0) begin bad++; $display("FAIL bp_mdv_stall%0d got=%b want=0", i, mdv_wbck_i_ready); end
            total++; if (oitf_ret_ena !== 1'b0) begin bad++; $display("FAIL bp_no_ret%0d got=%b want=0", i, oitf_ret_ena); end
            total++; if (longp_wbck_o_wdat !== 32'h0000AAAA) begin bad++; $display("FAIL bp_hold%0d got=%h want=0000aaaa", i, longp_wbck_o_wdat); end
            step();
        end
        longp_wbck_o_ready = 1'b1;
        settle();
        total++; if (mdv_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_accept got=%b want=1", mdv_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL bp_drain_ret got=%b want=1", oitf_ret_ena); end
        step();
        idle_inputs();
        longp_wbck_o_ready = 1'b0;
        oitf_ret_ptr = 2'd1;
        oitf_ret_rdwen = 1'b0;
        settle();
        total++; if (longp_wbck_o_valid !== 1'b1) begin bad++; $display("FAIL bp_full_after got=%b want=1", longp_wbck_o_valid); end
        total++; if (longp_wbck_o_wdat !== 32'h0000BBBB) begin bad++; $display("FAIL bp_new_wdat got=%h want=0000bbbb", longp_wbck_o_wdat); end
        total++; if (longp_wbck_o_rdidx !== 5'd6) begin bad++; $display("FAIL bp_new_rdidx got=%0d want=6", longp_wbck_o_rdidx); end
        // A non-writing completion bypasses the full, stalled slot.
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd1;
        lsu_wbck_i_wdat = 32'h0000CCCC;
        settle();
        total++; if (lsu_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL bp_bypass_ready got=%b want=1", lsu_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL bp_bypass_ret got=%b want=1", oitf_ret_ena); end
        step();
        idle_inputs();
        oitf_ret_ptr = 2'd2;
        settle();
        total++; if (longp_wbck_o_wdat !== 32'h0000BBBB) begin bad++; $display("FAIL bp_bypass_kept got=%h want=0000bbbb", longp_wbck_o_wdat); end
        longp_wbck_o_ready = 1'b1;
        step();
        settle();
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL bp_final_drain got=%b want=0", longp_wbck_o_valid); end
    endtask

    task automatic test_load_error();
        oitf_ret_ptr = 2'd2;
        oitf_ret_rdidx = 5'd3;
        oitf_ret_rdwen = 1'b1;
        longp_wbck_o_ready = 1'b1;
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd2;
        lsu_wbck_i_err = 1'b1;
        lsu_wbck_i_wdat = 32'h0BADF00D;
        settle();
        total++; if (lsu_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%b want=1", lsu_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL err_ret got=%b want=1", oitf_ret_ena); end
        step();
        idle_inputs();
        oitf_ret_ptr = 2'd3;
        settle();
        total++; if (longp_excp_o_valid !== 1'b1) begin bad++; $display("FAIL err_excp got=%b want=1", longp_excp_o_valid); end
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL err_no_wbck got=%b want=0", longp_wbck_o_valid); end
        step();
        settle();
        total++; if (longp_excp_o_valid !== 1'b0) begin bad++; $display("FAIL err_excp_pulse got=%b want=0", longp_excp_o_valid); end
    endtask

    task automatic test_priority_and_empty();
        oitf_ret_ptr = 2'd1;
        oitf_ret_rdwen = 1'b1;
        longp_wbck_o_ready = 1'b1;
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd1;
        mdv_wbck_i_valid = 1'b1;
        mdv_wbck_i_itag = 2'd1;
        oitf_empty = 1'b1;
        settle();
        total++; if (lsu_wbck_i_ready !== 1'b0) begin bad++; $display("FAIL empty_lsu got=%b want=0", lsu_wbck_i_ready); end
        total++; if (mdv_wbck_i_ready !== 1'b0) begin bad++; $display("FAIL empty_mdv got=%b want=0", mdv_wbck_i_ready); end
        total++; if (oitf_ret_ena !== 1'b0) begin bad++; $display("FAIL empty_ret got=%b want=0", oitf_ret_ena); end
        oitf_empty = 1'b0;
        settle();
        total++; if (lsu_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL prio_lsu got=%b want=1", lsu_wbck_i_ready); end
        total++; if (mdv_wbck_i_ready !== 1'b0) begin bad++; $display("FAIL prio_mdv got=%b want=0", mdv_wbck_i_ready); end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] vals [4];
        vals[0] = 32'h01020304;
        vals[1] = 32'hA5A5A5A5;
        vals[2] = 32'h5A5A5A5A;
        vals[3] = 32'hFFFF0000;
        longp_wbck_o_ready = 1'b1;
        oitf_ret_rdwen = 1'b1;
        mdv_wbck_i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                oitf_ret_ptr = ITAG_W'(i);
                oitf_ret_rdidx = RFIDX_W'(10 + i);
                mdv_wbck_i_itag = ITAG_W'(i);
                mdv_wbck_i_wdat = vals[i];
            end else begin
                mdv_wbck_i_valid = 1'b0;
            end
            settle();
            if (i < 4) begin
                total++; if (mdv_wbck_i_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, mdv_wbck_i_ready); end
            end
            if (i > 0) begin
                total++; if (longp_wbck_o_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%b want=1", i, longp_wbck_o_valid); end
                total++; if (longp_wbck_o_wdat !== vals[i-1]) begin bad++; $display("FAIL b2b_wdat%0d got=%h want=%h", i, longp_wbck_o_wdat, vals[i-1]); end
                total++; if (longp_wbck_o_rdidx !== RFIDX_W'(9 + i)) begin bad++; $display("FAIL b2b_rdidx%0d got=%0d want=%0d", i, longp_wbck_o_rdidx, 9 + i); end
            end
            step();
        end
        settle();
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b want=0", longp_wbck_o_valid); end
    endtask

    task automatic test_reset_mid();
        longp_wbck_o_ready = 1'b0;
        oitf_ret_ptr = 2'd0;
        oitf_ret_rdidx = 5'd17;
        oitf_ret_rdwen = 1'b1;
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd0;
        lsu_wbck_i_wdat = 32'hCAFE0001;
        step();
        idle_inputs();
        settle();
        total++; if (longp_wbck_o_valid !== 1'b1) begin bad++; $display("FAIL rmid_full got=%b want=1", longp_wbck_o_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", longp_wbck_o_valid); end
        total++; if (longp_wbck_o_wdat !== 32'h0) begin bad++; $display("FAIL rmid_wdat got=%h want=0", longp_wbck_o_wdat); end
        step();
        settle();
        total++; if (longp_wbck_o_valid !== 1'b0) begin bad++; $display("FAIL rmid_stays_empty got=%b want=0", longp_wbck_o_valid); end
    endtask

    task automatic test_timeout();
        oitf_empty = 1'b1;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        oitf_empty = 1'b0;
        oitf_ret_ptr = 2'd0;
        oitf_ret_rdwen = 1'b0;
`ifdef E203_LONGP_WBCK_TIMEOUT_EN
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        settle();
        total++; if (longp_wbck_timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", longp_wbck_timeout); end
        step();
        settle();
        total++; if (longp_wbck_timeout !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b want=1", longp_wbck_timeout); end
        lsu_wbck_i_valid = 1'b1;
        lsu_wbck_i_itag = 2'd0;
        settle();
        total++; if (oitf_ret_ena !== 1'b1) begin bad++; $display("FAIL tmo_accept got=%b want=1", oitf_ret_ena); end
        step();
        idle_inputs();
        step();
        settle();
        total++; if (longp_wbck_timeout !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", longp_wbck_timeout); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        total++; if (longp_wbck_timeout !== 1'b0) begin bad++; $display("FAIL tmo_cleared got=%b want=0", longp_wbck_timeout); end
`else
        for (int i = 0; i < TIMEOUT + 4; i++) step();
        settle();
        total++; if (longp_wbck_timeout !== 1'b0) begin bad++; $display("FAIL tmo_tied got=%b want=0", longp_wbck_timeout); end
`endif
    endtask

    initial begin
        test_reset();
        test_in_order_lsu();
        test_out_of_order();
        test_back_pressure();
        test_load_error();
        test_priority_and_empty();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
